// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared types, limits and parameter checks for the bus_mem dual-port memory model.
// Contents: port FSM state type, latency/wait-state limits, wait/pipe counter width,
//           and params_ok() used by the top level to reject illegal configurations.
package bus_mem_pkg;

  localparam int unsigned MAX_RD_LATENCY  = 4;
  localparam int unsigned MAX_WAIT_STATES = 15;

  // One counter serves both the wait phase and the read pipe phase.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PIPE = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  // Elaboration-time legality of a parameter set.
  function automatic bit params_ok(int unsigned data_width, int unsigned rd_latency,
                                   int unsigned wait_states);
    return (data_width >= 8) && ((data_width % 8) == 0) &&
           (rd_latency >= 1) && (rd_latency <= MAX_RD_LATENCY) &&
           (wait_states <= MAX_WAIT_STATES);
  endfunction

endpackage

// File: rtl/bus_mem_if.sv
// bus_mem_if: request/acknowledge bus of both bus_mem ports plus the collision flag.
// Master side drives cs/we/be/addr/wdata; slave side drives rdata/ack/collision.
interface bus_mem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2WORDS  = 14
);

  logic                    cs0, cs1;
  logic                    we0, we1;
  logic [DATA_WIDTH/8-1:0] be0, be1;
  logic [LOG2WORDS-1:0]    addr0, addr1;
  logic [DATA_WIDTH-1:0]   wdata0, wdata1;
  logic [DATA_WIDTH-1:0]   rdata0, rdata1;
  logic                    ack0, ack1;
  logic                    collision;

  modport master (
    output cs0, cs1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    input  rdata0, rdata1, ack0, ack1, collision
  );

  modport slave (
    input  cs0, cs1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    output rdata0, rdata1, ack0, ack1, collision
  );

endinterface

// File: rtl/bus_mem_port.sv
// bus_mem_port: one bus port of bus_mem -- request latch, IDLE/WAIT/PIPE/ACK FSM,
// wait counter, read pipeline and ack pulse.
// Ports: clk, nreset (sync, active low); cs_i/we_i/be_i/addr_i/wdata_i request inputs;
//        mem_rdata_i array word at req_addr_c_o; acc_c_o/req_*_c_o access strobe and
//        request fields for the array (combinational); rdata_o, ack_o registered outputs.
module bus_mem_port
  import bus_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LOG2WORDS   = 14,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    cs_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [LOG2WORDS-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    acc_c_o,
  output logic                    req_we_c_o,
  output logic [DATA_WIDTH/8-1:0] req_be_c_o,
  output logic [LOG2WORDS-1:0]    req_addr_c_o,
  output logic [DATA_WIDTH-1:0]   req_wdata_c_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ack_o
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [LOG2WORDS-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   pipe_q [RD_LATENCY];
  logic                    ack_q;

  logic                    acc_c;
  logic                    req_we_c;
  logic [DATA_WIDTH/8-1:0] req_be_c;
  logic [LOG2WORDS-1:0]    req_addr_c;
  logic [DATA_WIDTH-1:0]   req_wdata_c;

  // State and shared wait/pipe counter.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: an access either finishes (write, or single-stage read) or enters PIPE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (acc_c) begin
      if (req_we_c || (RD_LATENCY == 1)) begin
        state_d = ST_ACK;
      end else begin
        state_d = ST_PIPE;
        cnt_d   = CNT_W'(RD_LATENCY - 2);
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_i && (WAIT_STATES != 0)) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
        ST_WAIT: cnt_d = cnt_q - CNT_W'(1);
        ST_PIPE: begin
          if (cnt_q == '0) state_d = ST_ACK;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_ACK:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Access strobe and request fields; in IDLE the live inputs are used so a
  // zero-wait access can commit on the accepting edge. Reset blocks any commit.
  always_comb begin
    acc_c       = 1'b0;
    req_we_c    = we_q;
    req_be_c    = be_q;
    req_addr_c  = addr_q;
    req_wdata_c = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        acc_c       = cs_i && (WAIT_STATES == 0) && nreset;
        req_we_c    = we_i;
        req_be_c    = be_i;
        req_addr_c  = addr_i;
        req_wdata_c = wdata_i;
      end
      ST_WAIT: acc_c = (cnt_q == '0) && nreset;
      default: acc_c = 1'b0;
    endcase
  end

  // Request latch, captured only on acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && cs_i) begin
      we_q    <= we_i;
      be_q    <= be_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Read pipeline: stage 0 loads on a read access, stages shift only in PIPE so
  // the last stage holds the previous read result between transactions.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else if (acc_c && !req_we_c) begin
      pipe_q[0] <= mem_rdata_i;
    end else if (state_q == ST_PIPE) begin
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Ack pulse is high exactly for the cycle spent in ACK.
  always_ff @(posedge clk) begin
    if (!nreset) ack_q <= 1'b0;
    else         ack_q <= (state_d == ST_ACK);
  end

  assign acc_c_o       = acc_c;
  assign req_we_c_o    = req_we_c;
  assign req_be_c_o    = req_be_c;
  assign req_addr_c_o  = req_addr_c;
  assign req_wdata_c_o = req_wdata_c;
  assign rdata_o       = pipe_q[RD_LATENCY-1];
  assign ack_o         = ack_q;

endmodule

// File: rtl/bus_mem.sv
// bus_mem: dual-port synchronous memory model with request/ack handshaking, wait
// states, read pipeline latency, byte-lane writes and sticky write-collision flag.
// Ports: clk, nreset (sync, active low); bus (bus_mem_if.slave) carrying cs/we/be/addr/
//        wdata in and rdata/ack out for ports 0 and 1, plus the collision flag.
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LOG2WORDS   = 14,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic      clk,
  input  logic      nreset,
  bus_mem_if.slave  bus
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** LOG2WORDS;

  if (!params_ok(DATA_WIDTH, RD_LATENCY, WAIT_STATES)) begin : g_param_check
    $error("bus_mem: illegal DATA_WIDTH, RD_LATENCY or WAIT_STATES");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  collision_q;

  logic                  acc0_c, acc1_c;
  logic                  we0_c, we1_c;
  logic [BE_W-1:0]       be0_c, be1_c;
  logic [LOG2WORDS-1:0]  addr0_c, addr1_c;
  logic [DATA_WIDTH-1:0] wdata0_c, wdata1_c;
  logic [DATA_WIDTH-1:0] mem_rd0_c, mem_rd1_c;
  logic                  wr0_c, wr1_c;

  bus_mem_port #(
    .DATA_WIDTH (DATA_WIDTH), .LOG2WORDS (LOG2WORDS),
    .RD_LATENCY (RD_LATENCY), .WAIT_STATES (WAIT_STATES)
  ) u_port0 (
    .clk (clk), .nreset (nreset),
    .cs_i (bus.cs0), .we_i (bus.we0), .be_i (bus.be0), .addr_i (bus.addr0),
    .wdata_i (bus.wdata0), .mem_rdata_i (mem_rd0_c),
    .acc_c_o (acc0_c), .req_we_c_o (we0_c), .req_be_c_o (be0_c),
    .req_addr_c_o (addr0_c), .req_wdata_c_o (wdata0_c),
    .rdata_o (bus.rdata0), .ack_o (bus.ack0)
  );

  bus_mem_port #(
    .DATA_WIDTH (DATA_WIDTH), .LOG2WORDS (LOG2WORDS),
    .RD_LATENCY (RD_LATENCY), .WAIT_STATES (WAIT_STATES)
  ) u_port1 (
    .clk (clk), .nreset (nreset),
    .cs_i (bus.cs1), .we_i (bus.we1), .be_i (bus.be1), .addr_i (bus.addr1),
    .wdata_i (bus.wdata1), .mem_rdata_i (mem_rd1_c),
    .acc_c_o (acc1_c), .req_we_c_o (we1_c), .req_be_c_o (be1_c),
    .req_addr_c_o (addr1_c), .req_wdata_c_o (wdata1_c),
    .rdata_o (bus.rdata1), .ack_o (bus.ack1)
  );

  // Reads sample the array before this edge's writes land (read-first).
  assign mem_rd0_c = mem_q[addr0_c];
  assign mem_rd1_c = mem_q[addr1_c];

  assign wr0_c = acc0_c && we0_c;
  assign wr1_c = acc1_c && we1_c;

  // Byte-lane write; port 0 is applied last so its enabled lanes win a collision.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (wr1_c && be1_c[b]) mem_q[addr1_c][b*8 +: 8] <= wdata1_c[b*8 +: 8];
      if (wr0_c && be0_c[b]) mem_q[addr0_c][b*8 +: 8] <= wdata0_c[b*8 +: 8];
    end
  end

  // Sticky same-word, same-edge write collision.
  always_ff @(posedge clk) begin
    if (!nreset)                                     collision_q <= 1'b0;
    else if (wr0_c && wr1_c && (addr0_c == addr1_c)) collision_q <= 1'b1;
  end

  assign bus.collision = collision_q;

endmodule

// File: tb/tb_bus_mem.sv
// tb_bus_mem: scoreboard bench for bus_mem in three configurations
// (W=0/L=1, W=3/L=4, W=5/L=1). Port ids: 0,1 = default; 2,3 = W3L4; 4,5 = W5L1.
module tb_bus_mem;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q [6][$];

  bus_mem_if #(.DATA_WIDTH(32), .LOG2WORDS(14)) if_def ();
  bus_mem_if #(.DATA_WIDTH(32), .LOG2WORDS(8))  if_ws3 ();
  bus_mem_if #(.DATA_WIDTH(32), .LOG2WORDS(8))  if_ws5 ();

  bus_mem #(.DATA_WIDTH(32), .LOG2WORDS(14), .RD_LATENCY(1), .WAIT_STATES(0))
    u_def (.clk(clk), .nreset(nreset), .bus(if_def));
  bus_mem #(.DATA_WIDTH(32), .LOG2WORDS(8), .RD_LATENCY(4), .WAIT_STATES(3))
    u_ws3 (.clk(clk), .nreset(nreset), .bus(if_ws3));
  bus_mem #(.DATA_WIDTH(32), .LOG2WORDS(8), .RD_LATENCY(1), .WAIT_STATES(5))
    u_ws5 (.clk(clk), .nreset(nreset), .bus(if_ws5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ws_of(int id);
    return (id < 2) ? 0 : ((id < 4) ? 3 : 5);
  endfunction

  function automatic int lat_of(int id);
    return (id == 2 || id == 3) ? 4 : 1;
  endfunction

  task automatic drive(int id, bit cs, bit we, logic [3:0] be, logic [13:0] a, logic [31:0] wd);
    case (id)
      0: begin if_def.cs0 = cs; if_def.we0 = we; if_def.be0 = be; if_def.addr0 = a;      if_def.wdata0 = wd; end
      1: begin if_def.cs1 = cs; if_def.we1 = we; if_def.be1 = be; if_def.addr1 = a;      if_def.wdata1 = wd; end
      2: begin if_ws3.cs0 = cs; if_ws3.we0 = we; if_ws3.be0 = be; if_ws3.addr0 = a[7:0]; if_ws3.wdata0 = wd; end
      3: begin if_ws3.cs1 = cs; if_ws3.we1 = we; if_ws3.be1 = be; if_ws3.addr1 = a[7:0]; if_ws3.wdata1 = wd; end
      4: begin if_ws5.cs0 = cs; if_ws5.we0 = we; if_ws5.be0 = be; if_ws5.addr0 = a[7:0]; if_ws5.wdata0 = wd; end
      default: begin if_ws5.cs1 = cs; if_ws5.we1 = we; if_ws5.be1 = be; if_ws5.addr1 = a[7:0]; if_ws5.wdata1 = wd; end
    endcase
  endtask

  function automatic logic ack_of(int id);
    case (id)
      0:       return if_def.ack0;
      1:       return if_def.ack1;
      2:       return if_ws3.ack0;
      3:       return if_ws3.ack1;
      4:       return if_ws5.ack0;
      default: return if_ws5.ack1;
    endcase
  endfunction

  // One complete handshake; the expectation is queued when the request is driven.
  task automatic txn(int id, bit we, logic [3:0] be, logic [13:0] a, logic [31:0] wd,
                     logic [31:0] exp_rd);
    exp_t e;
    bit   got;
    @(negedge clk);
    drive(id, 1'b1, we, be, a, wd);
    e.rd   = !we;
    e.data = exp_rd;
    e.cyc  = cyc + 1 + ws_of(id) + (we ? 0 : lat_of(id) - 1);
    sb_q[id].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = ack_of(id);
    end
    chk($sformatf("p%0d_ack_seen", id), 32'(got), 32'd1);
    drive(id, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
  endtask

  // Scoreboard consumer: every ack must match a queued request, on time, with data.
  task automatic mon(int id, logic ack, logic [31:0] rd);
    exp_t e;
    if (ack) begin
      chk($sformatf("p%0d_ack_expected", id), 32'(sb_q[id].size() != 0), 32'd1);
      if (sb_q[id].size() != 0) begin
        e = sb_q[id].pop_front();
        chk($sformatf("p%0d_ack_cycle", id), 32'(cyc), 32'(e.cyc));
        if (e.rd) chk($sformatf("p%0d_rdata", id), rd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_def.ack0, if_def.rdata0);
    mon(1, if_def.ack1, if_def.rdata1);
    mon(2, if_ws3.ack0, if_ws3.rdata0);
    mon(3, if_ws3.ack1, if_ws3.rdata1);
    mon(4, if_ws5.ack0, if_ws5.rdata0);
    mon(5, if_ws5.ack1, if_ws5.rdata1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) drive(i, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack0",      32'(if_def.ack0),      32'd0);
    chk("rst_ack1",      32'(if_def.ack1),      32'd0);
    chk("rst_collision", 32'(if_def.collision), 32'd0);
    chk("rst_rdata_ws3", if_ws3.rdata0,         32'd0);
    nreset = 1'b1;

    // Default configuration: write then cross-port read.
    txn(0, 1'b1, 4'hF, 14'h10, 32'hDEADBEEF, 32'h0);
    txn(1, 1'b0, 4'hF, 14'h10, 32'h0, 32'hDEADBEEF);
    txn(0, 1'b1, 4'hF, 14'h3FFF, 32'h0BADF00D, 32'h0);
    txn(1, 1'b0, 4'h0, 14'h3FFF, 32'h0, 32'h0BADF00D);

    // Byte lanes.
    txn(0, 1'b1, 4'hF, 14'h18, 32'h11223344, 32'h0);
    txn(0, 1'b1, 4'h5, 14'h18, 32'hAABBCCDD, 32'h0);
    txn(1, 1'b0, 4'h0, 14'h18, 32'h0, 32'h11BB33DD);
    chk("collision_clear", 32'(if_def.collision), 32'd0);

    // Same-edge writes to one word.
    fork
      txn(0, 1'b1, 4'h1, 14'h20, 32'h00000001, 32'h0);
      txn(1, 1'b1, 4'hF, 14'h20, 32'hFFFFFFFF, 32'h0);
    join
    chk("collision_set", 32'(if_def.collision), 32'd1);
    txn(0, 1'b0, 4'h0, 14'h20, 32'h0, 32'hFFFFFF01);

    // Same-edge read (port 0) and write (port 1): read returns old data.
    txn(0, 1'b1, 4'hF, 14'h30, 32'h00000005, 32'h0);
    fork
      txn(0, 1'b0, 4'h0, 14'h30, 32'h0, 32'h00000005);
      txn(1, 1'b1, 4'hF, 14'h30, 32'hCAFE0000, 32'h0);
    join
    txn(0, 1'b0, 4'h0, 14'h30, 32'h0, 32'hCAFE0000);
    chk("collision_sticky", 32'(if_def.collision), 32'd1);

    // Three wait states, four pipeline stages.
    txn(2, 1'b1, 4'hF, 14'h10, 32'h12345678, 32'h0);
    txn(2, 1'b0, 4'h0, 14'h10, 32'h0, 32'h12345678);
    txn(3, 1'b0, 4'h0, 14'h10, 32'h0, 32'h12345678);
    txn(2, 1'b1, 4'hF, 14'h11, 32'hA5A5A5A5, 32'h0);
    chk("rdata_hold_after_write", if_ws3.rdata0, 32'h12345678);

    // Five wait states: reset abandons an in-flight write.
    txn(4, 1'b1, 4'hF, 14'h40, 32'h00000007, 32'h0);
    txn(4, 1'b0, 4'h0, 14'h40, 32'h0, 32'h00000007);
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 4'hF, 14'h40, 32'h00000099);
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    drive(4, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_ack_ws5",   32'(if_ws5.ack0),      32'd0);
    chk("post_rst_rdata_ws5", if_ws5.rdata0,         32'd0);
    chk("post_rst_collision", 32'(if_def.collision), 32'd0);
    chk("post_rst_rdata_def", if_def.rdata0,         32'd0);
    chk("post_rst_rdata_ws3", if_ws3.rdata0,         32'd0);
    txn(4, 1'b0, 4'h0, 14'h40, 32'h0, 32'h00000007);
    txn(5, 1'b1, 4'hF, 14'h40, 32'h00000055, 32'h0);
    txn(4, 1'b0, 4'h0, 14'h40, 32'h0, 32'h00000055);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("p%0d_sb_drain", i), 32'(sb_q[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
